// File: rtl/vector_scalar_mult.sv
// ----------------------------------------------------------------------------
// vector_scalar_mult
//   Scales every cell of a signed fixed-point vector by one signed fixed-point
//   scalar (e.g. gradient * learning rate). The block computes TILING cells per
//   cycle, saturates each result cell to RESULT_CELL_WIDTH, and raises error
//   when at least one cell of the current result saturated.
//
// Ports
//   clk_i             clock, rising edge
//   rst_i             synchronous, active-high reset
//   a_i               input vector, cell i at [i*A_CELL_WIDTH +: A_CELL_WIDTH]
//   a_valid_i         a_i holds a valid vector
//   a_ready_o         block can latch a_i
//   scalar_i          scalar multiplier, FRACTION fractional bits
//   scalar_valid_i    scalar_i valid
//   scalar_ready_o    block can latch scalar_i
//   result_o          scaled vector, same packing as a_i
//   result_valid_o    result_o and error_o valid
//   result_ready_i    consumer accepts result
//   error_o           at least one cell of this result saturated
//
// FSM
//   state | meaning
//   IDLE  | collecting operands; each one latched independently on its handshake
//   CALC  | computing one tile of TILING cells per cycle
//   DONE  | result presented, waiting for result_ready_i
// ----------------------------------------------------------------------------
module vector_scalar_mult #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int SCALAR_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION          = 4,
  parameter int TILING            = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a_i,
  input  logic                                  a_valid_i,
  output logic                                  a_ready_o,
  input  logic [SCALAR_WIDTH-1:0]               scalar_i,
  input  logic                                  scalar_valid_i,
  output logic                                  scalar_ready_o,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result_o,
  output logic                                  result_valid_o,
  input  logic                                  result_ready_i,
  output logic                                  error_o
);

  localparam int AW     = A_CELL_WIDTH;
  localparam int SW     = SCALAR_WIDTH;
  localparam int RW     = RESULT_CELL_WIDTH;
  localparam int PW     = AW + SW;
  localparam int NTILES = (VECTOR_LEN + TILING - 1) / TILING;
  localparam int CW     = (NTILES > 1) ? $clog2(NTILES) : 1;

  localparam logic [CW-1:0] LAST_TILE = CW'(NTILES - 1);

  // Saturation bounds expressed at full product width so the compare is signed.
  localparam logic signed [PW-1:0] RMAX = {{(PW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [PW-1:0] RMIN = ~RMAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [VECTOR_LEN*AW-1:0] a_lat_q, a_lat_d;
  logic [SW-1:0]          s_lat_q, s_lat_d;
  logic                   a_have_q, a_have_d;
  logic                   s_have_q, s_have_d;
  logic                   a_ready_q, a_ready_d;
  logic                   s_ready_q, s_ready_d;
  logic [VECTOR_LEN*RW-1:0] work_q, work_d;
  logic                   err_q, err_d;
  logic [VECTOR_LEN*RW-1:0] result_q, result_d;
  logic                   error_q, error_d;
  logic                   rvalid_q, rvalid_d;

  logic                   a_hs, s_hs;
  logic [AW-1:0]          tile_op   [TILING];
  logic [RW:0]            tile_cell [TILING];

  // Returns {saturated, cell}. The arithmetic shift floors toward -inf.
  function automatic logic [RW:0] sat_cell(input logic signed [AW-1:0] av,
                                           input logic signed [SW-1:0] sv);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;
    p = av * sv;
    q = p >>> FRACTION;
    if (q > RMAX) begin
      sat_cell = {1'b1, RMAX[RW-1:0]};
    end else if (q < RMIN) begin
      sat_cell = {1'b1, RMIN[RW-1:0]};
    end else begin
      sat_cell = {1'b0, q[RW-1:0]};
    end
  endfunction

  assign a_hs = (state_q == IDLE) && a_ready_q && a_valid_i;
  assign s_hs = (state_q == IDLE) && s_ready_q && scalar_valid_i;

  // Tile datapath: TILING shared multipliers, operands muxed by the tile count.
  always_comb begin
    for (int t = 0; t < TILING; t++) begin
      tile_op[t] = '0;
      for (int i = 0; i < VECTOR_LEN; i++) begin
        if ((i / TILING) == int'(cnt_q) && (i % TILING) == t) begin
          tile_op[t] = a_lat_q[i*AW +: AW];
        end
      end
      tile_cell[t] = sat_cell(tile_op[t], s_lat_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_lat_d   = a_lat_q;
    s_lat_d   = s_lat_q;
    a_have_d  = a_have_q;
    s_have_d  = s_have_q;
    a_ready_d = a_ready_q;
    s_ready_d = s_ready_q;
    work_d    = work_q;
    err_d     = err_q;
    result_d  = result_q;
    error_d   = error_q;
    rvalid_d  = rvalid_q;

    case (state_q)
      IDLE: begin
        if (a_hs) begin
          a_lat_d  = a_i;
          a_have_d = 1'b1;
        end
        if (s_hs) begin
          s_lat_d  = scalar_i;
          s_have_d = 1'b1;
        end
        // Readies rise on the first idle cycle and drop after their own latch.
        a_ready_d = !(a_have_q || a_hs);
        s_ready_d = !(s_have_q || s_hs);
        if ((a_have_q || a_hs) && (s_have_q || s_hs)) begin
          state_d   = CALC;
          cnt_d     = '0;
          err_d     = 1'b0;
          error_d   = 1'b0;
          a_ready_d = 1'b0;
          s_ready_d = 1'b0;
        end
      end

      CALC: begin
        for (int i = 0; i < VECTOR_LEN; i++) begin
          if ((i / TILING) == int'(cnt_q)) begin
            work_d[i*RW +: RW] = tile_cell[i % TILING][RW-1:0];
            err_d              = err_d | tile_cell[i % TILING][RW];
          end
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_TILE) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = work_d;
          error_d  = err_d;
          rvalid_d = 1'b1;
        end
      end

      DONE: begin
        if (result_ready_i) begin
          state_d   = IDLE;
          rvalid_d  = 1'b0;
          a_have_d  = 1'b0;
          s_have_d  = 1'b0;
          a_ready_d = 1'b1;
          s_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_lat_q   <= '0;
      s_lat_q   <= '0;
      a_have_q  <= 1'b0;
      s_have_q  <= 1'b0;
      a_ready_q <= 1'b0;
      s_ready_q <= 1'b0;
      work_q    <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      error_q   <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_lat_q   <= a_lat_d;
      s_lat_q   <= s_lat_d;
      a_have_q  <= a_have_d;
      s_have_q  <= s_have_d;
      a_ready_q <= a_ready_d;
      s_ready_q <= s_ready_d;
      work_q    <= work_d;
      err_q     <= err_d;
      result_q  <= result_d;
      error_q   <= error_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign a_ready_o      = a_ready_q;
  assign scalar_ready_o = s_ready_q;
  assign result_o       = result_q;
  assign result_valid_o = rvalid_q;
  assign error_o        = error_q;

endmodule
